data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of independent read/write request channels; matches the GPU's DATA_MEM_NUM_CHANNELS.
REQ-002 Parameter DEPTH, default 256: number of data_t words stored; address range 0..DEPTH-1.
REQ-003 Parameter LATENCY, default 2, legal range 1..15: number of cycles from request acceptance to the ready pulse.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 read_valid  input  [NUM_CHANNELS]  per-channel read request, held high by the requester until ready.
REQ-007 read_address  input  data_memory_address_t x NUM_CHANNELS  read address per channel.
REQ-008 read_ready  output  [NUM_CHANNELS]  one-cycle read completion pulse.
REQ-009 read_data  output  data_t x NUM_CHANNELS  read result; valid while read_ready is high.
REQ-010 write_valid  input  [NUM_CHANNELS]  per-channel write request, held high until ready.
REQ-011 write_address  input  data_memory_address_t x NUM_CHANNELS  write address per channel.
REQ-012 write_data  input  data_t x NUM_CHANNELS  write data per channel.
REQ-013 write_ready  output  [NUM_CHANNELS]  one-cycle write completion pulse.

Function
REQ-014 Each channel SHALL run one FSM with states IDLE, BUSY, RESPOND and RELEASE; a channel SHALL have at most one outstanding request.
REQ-015 IDLE: when read_valid or write_valid is high, the channel SHALL capture the address, the write data and the operation, load the latency counter with LATENCY-1, and go to BUSY.
REQ-016 IDLE with read_valid and write_valid both high: the read SHALL be accepted first, and the write SHALL be accepted on a later IDLE.
REQ-017 BUSY: the channel SHALL decrement the counter each cycle; when the counter is 0 it SHALL go to RESPOND.
REQ-018 On the BUSY->RESPOND edge the channel SHALL commit a write to the array or register the read data from the array.
REQ-019 RESPOND: the channel SHALL drive read_ready or write_ready high for exactly one cycle, then go to RELEASE.
REQ-020 Timing: a request first high in cycle 0 SHALL produce ready high in cycle LATENCY and in no other cycle.
REQ-021 RELEASE: the channel SHALL wait until the accepted request's valid is low, then go to IDLE; a back-to-back request SHALL therefore see at least one valid-low cycle.
REQ-022 Address, data or valid changes on a channel after acceptance SHALL be ignored until that channel returns to IDLE.
REQ-023 read_data SHALL hold its last value outside RESPOND.
REQ-024 An address >= DEPTH SHALL wrap modulo DEPTH; reads and writes to it SHALL still complete normally.
REQ-025 A read and a write to the same address committing on the same edge SHALL return the old value to the read.
REQ-026 Multiple writes to the same address committing on the same edge: the highest channel index SHALL win.
REQ-027 Channels SHALL be fully independent; no channel SHALL stall another.

Reset
REQ-028 While reset is high, every channel SHALL go to IDLE, the latency counters SHALL be cleared, read_ready and write_ready SHALL be 0, and read_data SHALL be 0.
REQ-029 Reset asserted mid-request SHALL abort the request without a ready pulse and without a pending write commit; array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DATA_MEM_ACCESS_COUNTERS_EN defined: the block SHALL add outputs read_count and write_count (32 bits each), which increment once per read or write ready pulse, sum all channels in a cycle, reset to 0, and wrap at 2^32.
REQ-031 Macro DATA_MEM_ACCESS_COUNTERS_EN undefined: those ports and counters SHALL be absent, with all other behaviour unchanged.

Verification
REQ-032 Test: LATENCY=2, channel 0 write addr 5 data 0xAB, valid high in cycle 0 -> write_ready high in cycle 2 only; drop valid, then read addr 5 -> read_ready pulse after 2 cycles with read_data=0xAB.
REQ-033 Test: channels 0..3 read different addresses in the same cycle -> all four read_ready pulse in the same cycle with the correct data each.
REQ-034 Test: channels 1 and 3 write addr 7 with 0x11 and 0x33 in the same cycle -> a later read of addr 7 returns 0x33.
REQ-035 Test: valid held high after the ready pulse -> no second ready pulse; valid low 1 cycle, then high -> new ready pulse LATENCY cycles later.
REQ-036 Test: reset asserted in BUSY of a write of 0x55 to addr 9 holding 0x00 -> no write_ready pulse; a subsequent read of addr 9 returns 0x00.
REQ-037 Test, with DATA_MEM_ACCESS_COUNTERS_EN defined: 3 reads and 2 writes completed -> read_count=3 and write_count=2; reset -> both 0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Multi-channel data memory responder: each channel accepts one read or write,
// responds after LATENCY cycles. Optional access counters: DATA_MEM_ACCESS_COUNTERS_EN.
module data_memory_responder #(
  parameter int NUM_CHANNELS = 4,
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 2,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CHANNELS-1:0]          read_valid,
  input  logic [NUM_CHANNELS*ADDR_W-1:0]   read_address,
  output logic [NUM_CHANNELS-1:0]          read_ready,
  output logic [NUM_CHANNELS*DATA_W-1:0]   read_data,
  input  logic [NUM_CHANNELS-1:0]          write_valid,
  input  logic [NUM_CHANNELS*ADDR_W-1:0]   write_address,
  input  logic [NUM_CHANNELS*DATA_W-1:0]   write_data,
  output logic [NUM_CHANNELS-1:0]          write_ready
`ifdef DATA_MEM_ACCESS_COUNTERS_EN
  ,
  output logic [31:0]                      read_count,
  output logic [31:0]                      write_count
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESPOND = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t            state_q   [NUM_CHANNELS];
  state_t            state_d   [NUM_CHANNELS];
  logic [3:0]        cnt_q     [NUM_CHANNELS];
  logic              op_wr_q   [NUM_CHANNELS];
  logic [IDX_W-1:0]  idx_q     [NUM_CHANNELS];
  logic [DATA_W-1:0] wdata_q   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] accept;
  logic [NUM_CHANNELS-1:0] accept_wr;
  logic [NUM_CHANNELS-1:0] commit;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [IDX_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    return IDX_W'(32'(a) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] ones(input logic [NUM_CHANNELS-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  // Next-state: a simultaneous read and write in IDLE takes the read first
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i]   = state_q[i];
      accept[i]    = 1'b0;
      accept_wr[i] = 1'b0;
      commit[i]    = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (read_valid[i] || write_valid[i]) begin
            accept[i]    = 1'b1;
            accept_wr[i] = ~read_valid[i];
            state_d[i]   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q[i] == 4'd0) begin
            commit[i]  = 1'b1;
            state_d[i] = ST_RESPOND;
          end
        end
        ST_RESPOND: state_d[i] = ST_RELEASE;
        ST_RELEASE: begin
          if (op_wr_q[i] ? !write_valid[i] : !read_valid[i]) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    read_ready  = '0;
    write_ready = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      read_ready[i]  = (state_q[i] == ST_RESPOND) && !op_wr_q[i];
      write_ready[i] = (state_q[i] == ST_RESPOND) &&  op_wr_q[i];
    end
  end

  // Control state and read result register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      read_data <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        if (accept[i])
          cnt_q[i] <= 4'(LATENCY - 1);
        else if (state_q[i] == ST_BUSY && cnt_q[i] != 4'd0)
          cnt_q[i] <= cnt_q[i] - 4'd1;
        if (commit[i] && !op_wr_q[i])
          read_data[i*DATA_W +: DATA_W] <= mem[idx_q[i]];
      end
    end
  end

  // Request capture; later input changes are ignored until the channel is IDLE again
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (accept[i]) begin
        op_wr_q[i] <= accept_wr[i];
        idx_q[i]   <= accept_wr[i] ? wrap_addr(write_address[i*ADDR_W +: ADDR_W])
                                   : wrap_addr(read_address[i*ADDR_W +: ADDR_W]);
        wdata_q[i] <= write_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ascending loop: the highest channel's write to a shared address lands last
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!reset && commit[i] && op_wr_q[i])
        mem[idx_q[i]] <= wdata_q[i];
    end
  end

`ifdef DATA_MEM_ACCESS_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      read_count  <= read_count  + ones(read_ready);
      write_count <= write_count + ones(write_ready);
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus randomized rounds
// against a transaction-level memory model.
module tb_data_memory_responder;

  localparam int NC    = 4;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int DW    = 8;
  localparam int AW    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     read_valid;
  logic [NC*AW-1:0]  read_address;
  logic [NC-1:0]     read_ready;
  logic [NC*DW-1:0]  read_data;
  logic [NC-1:0]     write_valid;
  logic [NC*AW-1:0]  write_address;
  logic [NC*DW-1:0]  write_data;
  logic [NC-1:0]     write_ready;
`ifdef DATA_MEM_ACCESS_COUNTERS_EN
  logic [31:0]       read_count;
  logic [31:0]       write_count;
`endif

  data_memory_responder #(
    .NUM_CHANNELS(NC), .DEPTH(DEPTH), .LATENCY(LAT), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(read_ready), .read_data(read_data),
    .write_valid(write_valid), .write_address(write_address),
    .write_data(write_data), .write_ready(write_ready)
`ifdef DATA_MEM_ACCESS_COUNTERS_EN
    , .read_count(read_count), .write_count(write_count)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model  [DEPTH];
  logic [DW-1:0] exp_rd [NC];
  logic [AW-1:0] r_addr [NC];
  logic [DW-1:0] r_data [NC];
  int total = 0;
  int bad   = 0;
  int exp_rc = 0;
  int exp_wc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input logic [NC-1:0] er, input logic [NC-1:0] ew);
    chk("read_ready", 32'(read_ready), 32'(er));
    chk("write_ready", 32'(write_ready), 32'(ew));
    for (int i = 0; i < NC; i++)
      chk($sformatf("read_data%0d", i), 32'(read_data[i*DW +: DW]), 32'(exp_rd[i]));
`ifdef DATA_MEM_ACCESS_COUNTERS_EN
    chk("read_count", read_count, 32'(exp_rc));
    chk("write_count", write_count, 32'(exp_wc));
`endif
  endtask

  // One transaction per enabled channel, all issued together; inputs are scrambled while busy
  task automatic run_round(input logic [NC-1:0] en, input logic [NC-1:0] wr);
    logic [DW-1:0] nxt [NC];
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      read_address[i*AW +: AW]  = r_addr[i];
      write_address[i*AW +: AW] = r_addr[i];
      write_data[i*DW +: DW]    = r_data[i];
    end
    read_valid  = en & ~wr;
    write_valid = en & wr;
    for (int i = 0; i < NC; i++) begin
      nxt[i] = exp_rd[i];
      if (en[i] && !wr[i]) nxt[i] = model[int'(r_addr[i]) % DEPTH];
    end
    for (int i = 0; i < NC; i++)
      if (en[i] && wr[i]) model[int'(r_addr[i]) % DEPTH] = r_data[i];
    for (int k = 0; k <= LAT + 2; k++) begin
      @(negedge clk);
      if (k == LAT) for (int i = 0; i < NC; i++) exp_rd[i] = nxt[i];
      check_all((k == LAT) ? (en & ~wr) : '0, (k == LAT) ? (en & wr) : '0);
      if (k == LAT) begin
        exp_rc += $countones(en & ~wr);
        exp_wc += $countones(en & wr);
      end
      read_address  = $urandom;
      write_address = $urandom;
      write_data    = $urandom;
    end
    read_valid  = '0;
    write_valid = '0;
    @(negedge clk);
    check_all('0, '0);
  endtask

  initial begin
    reset = 1'b1;
    read_valid = '0; write_valid = '0;
    read_address = '0; write_address = '0; write_data = '0;
    for (int i = 0; i < NC; i++) begin exp_rd[i] = '0; r_addr[i] = '0; r_data[i] = '0; end
    repeat (3) @(negedge clk);
    check_all('0, '0);
    reset = 1'b0;

    // Fill the whole array so every later read has a known value
    for (int base = 0; base < DEPTH; base += NC) begin
      for (int i = 0; i < NC; i++) begin
        r_addr[i] = AW'(base + i);
        r_data[i] = DW'($urandom);
      end
      run_round('1, '1);
    end

    // Write 0xAB to 5, read it back
    r_addr[0] = 8'd5; r_data[0] = 8'hAB;
    run_round(4'b0001, 4'b0001);
    run_round(4'b0001, 4'b0000);
    chk("rd5_const", 32'(read_data[0 +: DW]), 32'h0000_00AB);

    // Four simultaneous reads of different addresses
    for (int i = 0; i < NC; i++) r_addr[i] = AW'(i + 1);
    run_round('1, '0);

    // Channels 1 and 3 write the same address on the same edge
    r_addr[1] = 8'd7; r_data[1] = 8'h11;
    r_addr[3] = 8'd7; r_data[3] = 8'h33;
    run_round(4'b1010, 4'b1010);
    r_addr[2] = 8'd7;
    run_round(4'b0100, 4'b0000);
    chk("rd7_const", 32'(read_data[2*DW +: DW]), 32'h0000_0033);

    // Read and write both valid on channel 0: read first, write after read_valid drops
    begin
      logic [DW-1:0] old3;
      old3 = model[3];
      @(negedge clk);
      read_address[0 +: AW] = 8'd3; write_address[0 +: AW] = 8'd3;
      write_data[0 +: DW] = 8'hC3;
      read_valid = 4'b0001; write_valid = 4'b0001;
      for (int k = 0; k <= LAT + 1; k++) begin
        @(negedge clk);
        if (k == LAT) exp_rd[0] = old3;
        check_all((k == LAT) ? 4'b0001 : 4'b0000, '0);
        if (k == LAT) exp_rc++;
      end
      read_valid = '0;
      for (int j = 0; j <= LAT + 2; j++) begin
        @(negedge clk);
        check_all('0, (j == LAT + 1) ? 4'b0001 : 4'b0000);
        if (j == LAT + 1) exp_wc++;
      end
      model[3] = 8'hC3;
      write_valid = '0;
      @(negedge clk);
      check_all('0, '0);
      r_addr[0] = 8'd3;
      run_round(4'b0001, 4'b0000);
    end

    // Reset on the commit edge of a write of 0x55 to address 9 (holding 0x00)
    r_addr[0] = 8'd9; r_data[0] = 8'h00;
    run_round(4'b0001, 4'b0001);
    @(negedge clk);
    write_address[0 +: AW] = 8'd9; write_data[0 +: DW] = 8'h55;
    write_valid = 4'b0001;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      check_all('0, '0);
    end
    reset = 1'b1;
    write_valid = '0;
    @(negedge clk);
    for (int i = 0; i < NC; i++) exp_rd[i] = '0;
    exp_rc = 0; exp_wc = 0;
    check_all('0, '0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_all('0, '0);
    end
    r_addr[0] = 8'd9;
    run_round(4'b0001, 4'b0000);

    // Randomized rounds, addresses span beyond DEPTH to exercise wrap
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NC; i++) begin
        r_addr[i] = AW'($urandom_range(0, 255));
        r_data[i] = DW'($urandom);
      end
      run_round(NC'($urandom), NC'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
